// File: rtl/branch_tracker.sv
// branch_tracker: responder side of the BeeF branch-tracking interface.
// It updates the nesting-depth value for the branch controller and keeps a
// loop-address stack, so a repeating CBB jumps straight back into its loop.
// The opcode is instruction[8:6]: 3'b110 = CBF, 3'b111 = CBB, anything else is a no-op.
module branch_tracker #(
  parameter int PCWidth    = 16,
  parameter int StackDepth = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8:0]                    instruction,
  input  logic [7:0]                    working,
  input  logic [PCWidth-1:0]            pc,
  input  logic                          searching,
  input  logic [PCWidth-1:0]            branch_tracking_out,
  input  logic                          branch_tracking_op,
  output logic [PCWidth-1:0]            branch_tracking_in,
  output logic                          jump,
  output logic [PCWidth-1:0]            jump_target,
  output logic                          stack_empty,
  output logic                          stack_full,
  output logic [$clog2(StackDepth):0]   stack_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PtrW = $clog2(StackDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [2:0] OpCbf = 3'b110;
  localparam logic [2:0] OpCbb = 3'b111;
  localparam logic [CntW-1:0] CntFull = CntW'(StackDepth);

  logic [PCWidth-1:0] r_stack [StackDepth];
  logic [CntW-1:0]    r_count;
  logic [PCWidth-1:0] r_depth;
  logic               r_jump;
  logic [PCWidth-1:0] r_jump_target;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_is_cbf;
  logic               w_is_cbb;
  logic               w_wk_zero;
  logic               w_empty;
  logic               w_full;
  logic [CntW-1:0]    w_top_cnt;
  logic [PtrW-1:0]    w_top_idx;
  logic [PtrW-1:0]    w_push_idx;
  logic [PCWidth-1:0] w_top;
  logic               w_push;

  assign w_is_cbf   = (instruction[8:6] == OpCbf);
  assign w_is_cbb   = (instruction[8:6] == OpCbb);
  assign w_wk_zero  = (working == 8'd0);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntFull);
  // Index arithmetic only matters when an entry exists (top) or room exists (push).
  assign w_top_cnt  = r_count - CntW'(1);
  assign w_top_idx  = w_top_cnt[PtrW-1:0];
  assign w_push_idx = r_count[PtrW-1:0];
  assign w_top      = r_stack[w_top_idx];
  assign w_push     = !reset && !searching && w_is_cbf && w_wk_zero && !w_full;

  // Stack storage: data only, no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= pc;
    end
  end

  // Depth counter, stack pointer, jump pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth       <= '0;
      r_count       <= '0;
      r_jump        <= 1'b0;
      r_jump_target <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      // Depth follows the controller every cycle, even during a forward search.
      if (w_is_cbf || w_is_cbb) begin
        r_depth <= branch_tracking_op ? (branch_tracking_out - PCWidth'(1))
                                      : (branch_tracking_out + PCWidth'(1));
      end else begin
        r_depth <= branch_tracking_out;
      end

      // jump is a single-cycle pulse; only a qualifying CBB re-raises it.
      r_jump <= 1'b0;

      if (!searching) begin
        if (w_is_cbf && w_wk_zero) begin
          if (w_full) r_overflow <= 1'b1;
          else        r_count    <= r_count + CntW'(1);
        end else if (w_is_cbb) begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else if (w_wk_zero) begin
            r_jump        <= 1'b1;
            r_jump_target <= w_top + PCWidth'(1);
          end else begin
            r_count <= w_top_cnt;
          end
        end
      end
    end
  end

  assign branch_tracking_in = r_depth;
  assign jump               = r_jump;
  assign jump_target        = r_jump_target;
  assign stack_count        = r_count;
  assign stack_empty        = w_empty;
  assign stack_full         = w_full;
  assign overflow           = r_overflow;
  assign underflow          = r_underflow;

endmodule

// File: tb/tb_branch_tracker.sv
// Directed bench for branch_tracker: a default (depth 16) instance and a
// depth-4 instance share the same stimulus; each section checks the instance
// whose behaviour it targets.
module tb_branch_tracker;

  localparam logic [8:0] CBF = 9'b110_000000;
  localparam logic [8:0] CBB = 9'b111_000000;
  localparam logic [8:0] NOP = 9'b000_000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  instruction;
  logic [7:0]  working;
  logic [15:0] pc;
  logic        searching;
  logic [15:0] bt_out;
  logic        bt_op;

  logic [15:0] bti_a, jt_a;
  logic        jump_a, empty_a, full_a, ovf_a, unf_a;
  logic [4:0]  cnt_a;

  logic [15:0] bti_b, jt_b;
  logic        jump_b, empty_b, full_b, ovf_b, unf_b;
  logic [2:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_tracker #(.PCWidth(16), .StackDepth(16)) u_a (
    .clk(clk), .reset(reset), .instruction(instruction), .working(working),
    .pc(pc), .searching(searching), .branch_tracking_out(bt_out),
    .branch_tracking_op(bt_op), .branch_tracking_in(bti_a), .jump(jump_a),
    .jump_target(jt_a), .stack_empty(empty_a), .stack_full(full_a),
    .stack_count(cnt_a), .overflow(ovf_a), .underflow(unf_a)
  );

  branch_tracker #(.PCWidth(16), .StackDepth(4)) u_b (
    .clk(clk), .reset(reset), .instruction(instruction), .working(working),
    .pc(pc), .searching(searching), .branch_tracking_out(bt_out),
    .branch_tracking_op(bt_op), .branch_tracking_in(bti_b), .jump(jump_b),
    .jump_target(jt_b), .stack_empty(empty_b), .stack_full(full_b),
    .stack_count(cnt_b), .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the active edge.
  task automatic step(input logic rst, input logic [8:0] ins, input logic [7:0] wk,
                      input logic [15:0] p, input logic srch,
                      input logic [15:0] bo, input logic op);
    reset = rst; instruction = ins; working = wk; pc = p;
    searching = srch; bt_out = bo; bt_op = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instruction = NOP; working = '0; pc = '0;
    searching = 1'b0; bt_out = '0; bt_op = 1'b0;
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 9'($urandom), 8'($urandom), 16'($urandom), 1'($urandom),
           16'($urandom), 1'($urandom));
    end
    chk("rst_bti", bti_a, 0);
    chk("rst_jump", jump_a, 0);
    chk("rst_jt", jt_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_unf", unf_a, 0);

    // Depth counter (searching=1 keeps the stack out of it)
    step(1'b0, CBF, 8'd1, 16'h0, 1'b1, 16'd5, 1'b0);
    chk("depth_inc", bti_a, 16'd6);
    step(1'b0, CBB, 8'd1, 16'h0, 1'b1, 16'd6, 1'b1);
    chk("depth_dec", bti_a, 16'd5);
    step(1'b0, NOP, 8'd1, 16'h0, 1'b1, 16'd3, 1'b1);
    chk("depth_nop", bti_a, 16'd3);
    step(1'b0, CBB, 8'd1, 16'h0, 1'b1, 16'd0, 1'b1);
    chk("depth_wrap", bti_a, 16'hFFFF);
    chk("depth_cnt", cnt_a, 0);
    chk("depth_unf", unf_a, 0);

    // Single loop
    step(1'b0, CBF, 8'd0, 16'h0010, 1'b0, 16'd0, 1'b0);
    chk("loop_push_cnt", cnt_a, 1);
    chk("loop_push_empty", empty_a, 0);
    step(1'b0, CBB, 8'd0, 16'h0020, 1'b0, 16'd1, 1'b1);
    chk("loop_rep_jump", jump_a, 1);
    chk("loop_rep_jt", jt_a, 16'h0011);
    chk("loop_rep_cnt", cnt_a, 1);
    step(1'b0, NOP, 8'd0, 16'h0021, 1'b0, 16'd1, 1'b0);
    chk("loop_pulse_end", jump_a, 0);
    chk("loop_jt_hold", jt_a, 16'h0011);
    step(1'b0, CBB, 8'd3, 16'h0020, 1'b0, 16'd1, 1'b1);
    chk("loop_exit_jump", jump_a, 0);
    chk("loop_exit_cnt", cnt_a, 0);
    chk("loop_exit_empty", empty_a, 1);

    // Nesting
    step(1'b0, CBF, 8'd0, 16'h0010, 1'b0, 16'd0, 1'b0);
    step(1'b0, CBF, 8'd0, 16'h0020, 1'b0, 16'd1, 1'b0);
    step(1'b0, CBF, 8'd0, 16'h0030, 1'b0, 16'd2, 1'b0);
    chk("nest_cnt3", cnt_a, 3);
    step(1'b0, CBB, 8'd0, 16'h0040, 1'b0, 16'd3, 1'b1);
    chk("nest_jt31", jt_a, 16'h0031);
    chk("nest_jump1", jump_a, 1);
    step(1'b0, CBB, 8'd0, 16'h0040, 1'b0, 16'd3, 1'b1);
    chk("nest_b2b_jump", jump_a, 1);
    chk("nest_b2b_jt", jt_a, 16'h0031);
    step(1'b0, CBB, 8'd2, 16'h0040, 1'b0, 16'd3, 1'b1);
    chk("nest_exit1_cnt", cnt_a, 2);
    chk("nest_exit1_jump", jump_a, 0);
    step(1'b0, CBB, 8'd0, 16'h0050, 1'b0, 16'd2, 1'b1);
    chk("nest_jt21", jt_a, 16'h0021);
    step(1'b0, CBB, 8'd2, 16'h0050, 1'b0, 16'd2, 1'b1);
    step(1'b0, CBB, 8'd0, 16'h0060, 1'b0, 16'd1, 1'b1);
    chk("nest_jt11", jt_a, 16'h0011);
    chk("nest_cnt1", cnt_a, 1);

    // Searching freezes the stack and jump, not the depth counter
    step(1'b0, CBF, 8'd0, 16'h0070, 1'b1, 16'd7, 1'b0);
    chk("srch_cbf_cnt", cnt_a, 1);
    chk("srch_cbf_bti", bti_a, 16'd8);
    step(1'b0, CBB, 8'd0, 16'h0080, 1'b1, 16'd8, 1'b1);
    chk("srch_cbb_jump", jump_a, 0);
    chk("srch_cbb_cnt", cnt_a, 1);
    chk("srch_cbb_bti", bti_a, 16'd7);
    step(1'b0, CBB, 8'd1, 16'h0080, 1'b0, 16'd1, 1'b1);
    chk("srch_exit_cnt", cnt_a, 0);
    chk("srch_unf", unf_a, 0);

    // Reset mid-loop suppresses a pending jump
    step(1'b0, CBF, 8'd0, 16'h0090, 1'b0, 16'd0, 1'b0);
    step(1'b1, CBB, 8'd0, 16'h00A0, 1'b0, 16'd1, 1'b1);
    chk("midrst_jump", jump_a, 0);
    chk("midrst_cnt", cnt_a, 0);
    chk("midrst_empty", empty_a, 1);

    // Depth-4 instance: overflow, underflow, reset
    step(1'b1, NOP, 8'd0, 16'h0, 1'b0, 16'd0, 1'b0);
    chk("d4_rst_cnt", cnt_b, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, CBF, 8'd0, 16'h0100 + 16'(i), 1'b0, 16'd0, 1'b0);
      if (i == 2) begin
        chk("d4_full_after3", full_b, 0);
      end
      if (i == 3) begin
        chk("d4_full_after4", full_b, 1);
        chk("d4_ovf_after4", ovf_b, 0);
      end
    end
    chk("d4_ovf_after5", ovf_b, 1);
    chk("d4_cnt4", cnt_b, 4);
    step(1'b0, CBB, 8'd0, 16'h0200, 1'b0, 16'd0, 1'b1);
    chk("d4_top_jt", jt_b, 16'h0104);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, CBB, 8'd1, 16'h0200, 1'b0, 16'd0, 1'b1);
    end
    chk("d4_empty", empty_b, 1);
    chk("d4_unf_before", unf_b, 0);
    step(1'b0, CBB, 8'd0, 16'h0200, 1'b0, 16'd0, 1'b1);
    chk("d4_unf", unf_b, 1);
    chk("d4_unf_nojump", jump_b, 0);
    chk("d4_ovf_sticky", ovf_b, 1);
    step(1'b1, NOP, 8'd0, 16'h0, 1'b0, 16'd0, 1'b0);
    chk("d4_rst_ovf", ovf_b, 0);
    chk("d4_rst_unf", unf_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
